// File: rtl/mem_dma.sv
// Block copy / block fill initiator for the single-port data memory.
// One word per READ+WRITE pair in copy mode, one word per WRITE in fill mode.
module mem_dma #(
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] wd_q, wd_d;

  logic [32:0]      src_end, dst_end;
  logic             range_err;
  logic [LEN_W-1:0] wd_inc;

  // Word-index end points in 33 bits so a huge byte address cannot wrap past the limit.
  assign src_end   = 33'(src_addr >> 2) + 33'(len);
  assign dst_end   = 33'(dst_addr >> 2) + 33'(len);
  assign range_err = (dst_end > 33'(DEPTH_WORDS)) ||
                     (!mode && (src_end > 33'(DEPTH_WORDS)));
  assign wd_inc    = wd_q + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    data_d  = data_q;
    err_d   = err_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src_addr & 32'hFFFF_FFFC;
          dst_d  = dst_addr & 32'hFFFF_FFFC;
          len_d  = len;
          fill_d = fill_val;
          err_d  = range_err;
          wd_d   = '0;
          if (range_err || (len == '0)) state_d = S_DONE;
          else if (mode)                state_d = S_WRITE;
          else                          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = mem_rd;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d = dst_q + 32'd4;
        if (!mode_q) src_d = src_q + 32'd4;
        wd_d = wd_inc;
        if (wd_inc == len_q) state_d = S_DONE;
        else if (mode_q)     state_d = S_WRITE;
        else                 state_d = S_READ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops mem_we without a clock.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    err        = err_q;
    words_done = wd_q;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    unique case (state_q)
      S_READ:  mem_a = src_q;
      S_WRITE: begin
        mem_we = 1'b1;
        mem_a  = dst_q;
        mem_wd = mode_q ? fill_q : data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: requests push expected completions into a scoreboard,
// a negedge monitor pops and checks them whenever done is seen.
module tb_mem_dma;
  localparam int DW = 64;
  localparam int LW = 16;

  typedef struct {
    logic          err;
    logic [LW-1:0] wd;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [31:0]   src_addr = '0, dst_addr = '0, fill_val = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err, mem_we;
  logic [LW-1:0] words_done;
  logic [31:0]   mem_a, mem_wd, mem_rd;
  logic [31:0]   mem [0:DW-1];

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, we_cnt = 0, run = 0, last_run = 0, align_bad = 0;
  int we0;

  mem_dma #(.DEPTH_WORDS(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_a[1:0] != 2'b00 || mem_a[31:8] != '0) align_bad++;
    if (mem_we) begin
      we_cnt++;
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cyc %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_err", 32'(err), 32'(e.err));
        chk("done_words", 32'(words_done), 32'(e.wd));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < DW; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
  endtask

  // lat = edges after the accepting edge before done is seen
  task automatic req(input logic m, input logic [31:0] s, input logic [31:0] d,
                     input logic [LW-1:0] l, input logic [31:0] f,
                     input logic eerr, input logic [LW-1:0] ewd, input int lat);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
    sb.push_back('{err: eerr, wd: ewd, cyc: cyc + 1 + lat});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; fill_val = $urandom;
    len = LW'($urandom); mode = ~m;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    init_mem();
    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_a", mem_a, 0);
    chk("rst_wd", mem_wd, 0);
    chk("rst_words", 32'(words_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // copy basic, with an ignored start pulse while busy
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    we0 = we_cnt;
    req(1'b0, 32'h0, 32'h40, 16'd4, 32'h0, 1'b0, 16'd4, 8);
    repeat (2) @(negedge clk);
    chk("busy_mid_copy", 32'(busy), 1);
    mode = 1'b1; dst_addr = 32'h0; len = 16'd2; fill_val = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("copy_w16", mem[16], 32'd11);
    chk("copy_w17", mem[17], 32'd22);
    chk("copy_w18", mem[18], 32'd33);
    chk("copy_w19", mem[19], 32'd44);
    chk("copy_w20", mem[20], 32'hA5A5_0014);
    chk("copy_src0", mem[0], 32'd11);
    chk("copy_src1", mem[1], 32'd22);
    chk("copy_writes", we_cnt - we0, 4);
    chk("copy_idle_busy", 32'(busy), 0);

    // fill
    we0 = we_cnt;
    req(1'b1, 32'h0, 32'h10, 16'd3, 32'hDEAD_BEEF, 1'b0, 16'd3, 3);
    wait_done();
    chk("fill_w4", mem[4], 32'hDEAD_BEEF);
    chk("fill_w5", mem[5], 32'hDEAD_BEEF);
    chk("fill_w6", mem[6], 32'hDEAD_BEEF);
    chk("fill_w7", mem[7], 32'hA5A5_0007);
    chk("fill_writes", we_cnt - we0, 3);
    chk("fill_run", last_run, 3);
    chk("fill_words_hold", 32'(words_done), 3);

    // range errors and zero length
    we0 = we_cnt;
    req(1'b0, 32'h0, 32'hF8, 16'd3, 32'h0, 1'b1, 16'd0, 0);
    wait_done();
    chk("err_hold", 32'(err), 1);
    req(1'b1, 32'h0, 32'h0, 16'd0, 32'h1, 1'b0, 16'd0, 0);
    wait_done();
    chk("len0_err", 32'(err), 0);
    req(1'b0, 32'hF0, 32'h0, 16'd8, 32'h0, 1'b1, 16'd0, 0);
    wait_done();
    chk("err_writes", we_cnt - we0, 0);
    chk("err_w0", mem[0], 32'd11);

    // fill reaching exactly the last word
    req(1'b1, 32'h0, 32'hF4, 16'd3, 32'h0BAD_F00D, 1'b0, 16'd3, 3);
    wait_done();
    chk("edge_w61", mem[61], 32'h0BAD_F00D);
    chk("edge_w63", mem[63], 32'h0BAD_F00D);
    chk("edge_w60", mem[60], 32'hA5A5_003C);

    // misaligned addresses are truncated
    init_mem();
    req(1'b0, 32'h2, 32'h43, 16'd2, 32'h0, 1'b0, 16'd2, 4);
    wait_done();
    chk("mis_w16", mem[16], 32'hA5A5_0000);
    chk("mis_w17", mem[17], 32'hA5A5_0001);
    chk("mis_w18", mem[18], 32'hA5A5_0012);

    // async reset during the third WRITE of a len=8 copy
    init_mem();
    req(1'b0, 32'h0, 32'h40, 16'd8, 32'h0, 1'b0, 16'd8, 16);
    repeat (5) @(negedge clk);
    chk("pre_rst_we", 32'(mem_we), 1);
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_words", 32'(words_done), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("arst_w16", mem[16], 32'hA5A5_0000);
    chk("arst_w17", mem[17], 32'hA5A5_0001);
    chk("arst_w18", mem[18], 32'hA5A5_0012);
    chk("arst_w23", mem[23], 32'hA5A5_0017);
    req(1'b1, 32'h0, 32'h20, 16'd2, 32'h1234_5678, 1'b0, 16'd2, 2);
    wait_done();
    chk("post_w8", mem[8], 32'h1234_5678);
    chk("post_w9", mem[9], 32'h1234_5678);
    chk("post_w10", mem[10], 32'hA5A5_000A);

    // overlapping copy replicates the first source word
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    req(1'b0, 32'h0, 32'h4, 16'd3, 32'h0, 1'b0, 16'd3, 6);
    wait_done();
    chk("ovl_w0", mem[0], 32'd1);
    chk("ovl_w1", mem[1], 32'd1);
    chk("ovl_w2", mem[2], 32'd1);
    chk("ovl_w3", mem[3], 32'd1);
    chk("ovl_w4", mem[4], 32'hA5A5_0004);

    chk("addr_align", align_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
